// File: rtl/rgmii_rx_frame_if.sv
// Byte-stream bundle between the RGMII receive DDR cell and the receive frame stage,
// plus the payload stream the frame stage delivers to its sink.
interface rgmii_rx_frame_if;
   logic       rx_dv;
   logic       rx_er;
   logic [7:0] rx_data;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_sof;
   logic       m_eof;
   logic       m_err;

   modport master (
      input  rx_dv, rx_er, rx_data,
      output m_data, m_valid, m_sof, m_eof, m_err
   );

   modport slave (
      output rx_dv, rx_er, rx_data,
      input  m_data, m_valid, m_sof, m_eof, m_err
   );
endinterface

// File: rtl/rgmii_rx_frame.sv
// RGMII receive frame stage: strips preamble/SFD and FCS, checks CRC-32, length and PHY
// error, delivers payload with sof/eof/err markers and keeps saturating good/bad counters.
module rgmii_rx_frame #(
   parameter int MAX_LEN = 1518,
   parameter int MIN_LEN = 64
) (
   input  logic              rxclk,
   input  logic              rst,
   rgmii_rx_frame_if.master  bus,
   output logic [15:0]       good_cnt,
   output logic [15:0]       bad_cnt
);

   localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
   localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t          state, state_nxt;
   logic [4:0][7:0] dly;
   logic [10:0]     len;
   logic [31:0]     crc;
   logic            er_flag;
   logic            frame_bad;

   logic emit, emit_sof, emit_eof, emit_err;
   logic good_inc, bad_inc, start, take;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A frame is judged on the residue left after the FCS bytes have been folded in.
   assign frame_bad = (crc != RESIDUE) || er_flag || (len < MIN_L);

   always_ff @(posedge rxclk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      emit_sof  = 1'b0;
      emit_eof  = 1'b0;
      emit_err  = 1'b0;
      good_inc  = 1'b0;
      bad_inc   = 1'b0;
      start     = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE, PREAMBLE: begin
            if (!bus.rx_dv) begin
               state_nxt = IDLE;
            end else if (bus.rx_data == 8'h55) begin
               state_nxt = PREAMBLE;
            end else if (bus.rx_data == 8'hD5) begin
               state_nxt = DATA;
               start     = 1'b1;
            end else begin
               state_nxt = DROP;
            end
         end
         DATA: begin
            if (!bus.rx_dv) begin
               state_nxt = IDLE;
               if (len >= 11'd5) begin
                  emit     = 1'b1;
                  emit_sof = (len == 11'd5);
                  emit_eof = 1'b1;
                  emit_err = frame_bad;
                  good_inc = !frame_bad;
                  bad_inc  = frame_bad;
               end else begin
                  bad_inc  = 1'b1;
               end
            end else if (len == MAX_L) begin
               // Oversize: close the frame with the byte already in the delay line.
               state_nxt = DROP;
               emit      = 1'b1;
               emit_sof  = (len == 11'd5);
               emit_eof  = 1'b1;
               emit_err  = 1'b1;
               bad_inc   = 1'b1;
            end else begin
               take     = 1'b1;
               emit     = (len >= 11'd5);
               emit_sof = (len == 11'd5);
            end
         end
         DROP: begin
            if (!bus.rx_dv) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rxclk) begin
      if (rst) begin
         dly         <= '0;
         len         <= '0;
         crc         <= '1;
         er_flag     <= 1'b0;
         bus.m_data  <= '0;
         bus.m_valid <= 1'b0;
         bus.m_sof   <= 1'b0;
         bus.m_eof   <= 1'b0;
         bus.m_err   <= 1'b0;
         good_cnt    <= '0;
         bad_cnt     <= '0;
      end else begin
         if (start) begin
            len     <= '0;
            crc     <= '1;
            er_flag <= 1'b0;
         end
         if (take) begin
            dly <= {dly[3:0], bus.rx_data};
            crc <= crc_byte(crc, bus.rx_data);
            len <= len + 11'd1;
            if (bus.rx_er) er_flag <= 1'b1;
         end
         // Output stage: byte i leaves the delay line on the edge sampling byte i+5.
         bus.m_valid <= emit;
         bus.m_data  <= emit ? dly[4] : 8'h00;
         bus.m_sof   <= emit_sof;
         bus.m_eof   <= emit_eof;
         bus.m_err   <= emit_err;
         if (good_inc) good_cnt <= sat_inc(good_cnt);
         if (bad_inc)  bad_cnt  <= sat_inc(bad_cnt);
      end
   end

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Directed bench for rgmii_rx_frame: builds frames with a bit-serial FCS and compares the
// delivered payload stream and counters against hand-computed strobe counts.
module tb_rgmii_rx_frame;

   logic        rxclk = 1'b0;
   logic        rst   = 1'b1;
   logic [15:0] good_cnt, bad_cnt;

   rgmii_rx_frame_if bus();

   rgmii_rx_frame #(.MAX_LEN(100), .MIN_LEN(64)) dut (
      .rxclk    (rxclk),
      .rst      (rst),
      .bus      (bus.master),
      .good_cnt (good_cnt),
      .bad_cnt  (bad_cnt)
   );

   always #4 rxclk = ~rxclk;

   int checks = 0;
   int errors = 0;
   int stray  = 0;

   logic [7:0] frm [0:255];
   logic [7:0] got_d [$];
   logic       got_s [$], got_e [$], got_r [$];
   logic [7:0] exp_d [$];
   logic       exp_s [$], exp_e [$], exp_r [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge rxclk) begin
      if (bus.m_valid) begin
         got_d.push_back(bus.m_data);
         got_s.push_back(bus.m_sof);
         got_e.push_back(bus.m_eof);
         got_r.push_back(bus.m_err);
      end else if (bus.m_sof || bus.m_eof || bus.m_err) begin
         stray++;
      end
   end

   function automatic logic [7:0] pat(input int i, input int seed);
      logic [7:0] b;
      b = 8'(i * 7 + seed * 13 + 1);
      if (b == 8'h55 || b == 8'hD5) b = b ^ 8'h01;
      return b;
   endfunction

   task automatic put(input logic dv, input logic er, input logic [7:0] d);
      bus.rx_dv   = dv;
      bus.rx_er   = er;
      bus.rx_data = d;
      @(posedge rxclk);
      #1;
   endtask

   task automatic build(input int n, input int seed, input bit bad_fcs);
      logic [31:0] c;
      logic [31:0] fcs;
      logic        fb;
      for (int i = 0; i < n; i++) frm[i] = pat(i, seed);
      if (n >= 4) begin
         c = 32'hFFFFFFFF;
         for (int i = 0; i < n - 4; i++)
            for (int k = 0; k < 8; k++) begin
               fb = c[0] ^ frm[i][k];
               c  = c >> 1;
               if (fb) c = c ^ 32'hEDB88320;
            end
         fcs = ~c;
         for (int j = 0; j < 4; j++) frm[n - 4 + j] = fcs[8*j +: 8];
         if (bad_fcs) frm[n - 1] = frm[n - 1] ^ 8'h01;
      end
   endtask

   task automatic send(input int n, input int er_idx, input bit er_pre, input bit pre_bad,
                       input int rst_idx, input int gap);
      for (int p = 0; p < 7; p++) put(1'b1, er_pre, (pre_bad && p == 3) ? 8'h54 : 8'h55);
      put(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < n; i++) begin
         if (i == rst_idx) begin
            rst = 1'b1;
            put(1'b1, 1'b0, frm[i]);
            rst = 1'b0;
            check("rst_valid", bus.m_valid, 1'b0);
            check("rst_good", good_cnt, 16'd0);
         end else begin
            put(1'b1, (i == er_idx), frm[i]);
         end
      end
      for (int g = 0; g < gap; g++) put(1'b0, 1'b0, 8'h00);
   endtask

   task automatic expect_bytes(input int nemit, input bit with_eof, input bit err);
      for (int i = 0; i < nemit; i++) begin
         exp_d.push_back(frm[i]);
         exp_s.push_back(i == 0);
         exp_e.push_back(with_eof && (i == nemit - 1));
         exp_r.push_back(with_eof && err && (i == nemit - 1));
      end
   endtask

   task automatic compare(input string tag);
      int dm, sm, em, rm, n;
      dm = 0; sm = 0; em = 0; rm = 0;
      check({tag, "_strobes"}, got_d.size(), exp_d.size());
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         if (got_d[i] !== exp_d[i]) dm++;
         if (got_s[i] !== exp_s[i]) sm++;
         if (got_e[i] !== exp_e[i]) em++;
         if (got_r[i] !== exp_r[i]) rm++;
      end
      check({tag, "_data"}, dm, 0);
      check({tag, "_sof"},  sm, 0);
      check({tag, "_eof"},  em, 0);
      check({tag, "_err"},  rm, 0);
      got_d.delete(); got_s.delete(); got_e.delete(); got_r.delete();
      exp_d.delete(); exp_s.delete(); exp_e.delete(); exp_r.delete();
   endtask

   initial begin
      bus.rx_dv   = 1'b0;
      bus.rx_er   = 1'b0;
      bus.rx_data = 8'h00;
      repeat (3) @(posedge rxclk);
      #1;
      rst = 1'b0;
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_m_data", bus.m_data, 8'h00);
      check("rst_m_sof", bus.m_sof, 1'b0);
      check("rst_m_eof", bus.m_eof, 1'b0);
      check("rst_m_err", bus.m_err, 1'b0);
      check("rst_good_cnt", good_cnt, 16'd0);
      check("rst_bad_cnt", bad_cnt, 16'd0);
      put(1'b0, 1'b0, 8'h00);

      build(64, 1, 1'b0);
      send(64, -1, 1'b0, 1'b0, -1, 4);
      expect_bytes(60, 1'b1, 1'b0);
      compare("good64");
      check("good64_good", good_cnt, 16'd1);
      check("good64_bad", bad_cnt, 16'd0);

      build(64, 1, 1'b1);
      send(64, -1, 1'b0, 1'b0, -1, 4);
      expect_bytes(60, 1'b1, 1'b1);
      compare("badfcs");
      check("badfcs_bad", bad_cnt, 16'd1);

      build(100, 2, 1'b0);
      send(100, 20, 1'b0, 1'b0, -1, 4);
      expect_bytes(96, 1'b1, 1'b1);
      compare("rxer_data");
      check("rxer_data_bad", bad_cnt, 16'd2);

      send(100, -1, 1'b1, 1'b0, -1, 4);
      expect_bytes(96, 1'b1, 1'b0);
      compare("rxer_pre");
      check("rxer_pre_good", good_cnt, 16'd2);

      build(40, 3, 1'b0);
      send(40, -1, 1'b0, 1'b0, -1, 4);
      expect_bytes(36, 1'b1, 1'b1);
      compare("runt40");
      check("runt40_bad", bad_cnt, 16'd3);

      build(3, 4, 1'b0);
      send(3, -1, 1'b0, 1'b0, -1, 4);
      compare("runt3");
      check("runt3_bad", bad_cnt, 16'd4);

      build(120, 5, 1'b0);
      send(120, -1, 1'b0, 1'b0, -1, 1);
      expect_bytes(96, 1'b1, 1'b1);
      build(64, 6, 1'b0);
      send(64, -1, 1'b0, 1'b0, -1, 4);
      expect_bytes(60, 1'b1, 1'b0);
      compare("oversize_b2b");
      check("oversize_bad", bad_cnt, 16'd5);
      check("b2b_good", good_cnt, 16'd3);

      send(64, -1, 1'b0, 1'b1, -1, 4);
      compare("pre54");
      check("pre54_good", good_cnt, 16'd3);
      check("pre54_bad", bad_cnt, 16'd5);

      build(64, 7, 1'b0);
      send(64, -1, 1'b0, 1'b0, 30, 4);
      expect_bytes(25, 1'b0, 1'b0);
      compare("rst_mid");
      check("rst_mid_good", good_cnt, 16'd0);
      check("rst_mid_bad", bad_cnt, 16'd0);
      send(64, -1, 1'b0, 1'b0, -1, 4);
      expect_bytes(60, 1'b1, 1'b0);
      compare("after_rst");
      check("after_rst_good", good_cnt, 16'd1);
      check("after_rst_bad", bad_cnt, 16'd0);

      check("stray_markers", stray, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
